psum_collector: RTL
===================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter IMG_WIDTH, default 10, input feature-map width and height in pixels.
REQ-002 Parameter KERNEL_SIZE, default 3, square kernel edge; stride is fixed at 1.
REQ-003 Parameter START_LAT, default 6, cycles from start to the first valid Q sample (PE_Y pipeline plus accumulator stages).
REQ-004 Derived: OUT_W = IMG_WIDTH-KERNEL_SIZE+1 (8); ROW_PERIOD = IMG_WIDTH+KERNEL_SIZE-1 (12); OUT_PIX = OUT_W*OUT_W (64); AW = clog2(OUT_PIX) (6).
REQ-005 sys_clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse, aligned with the first column presented to the PE array.
REQ-008 en  in  1  stream enable, same signal that gates the PE array; low freezes all counters.
REQ-009 Q  in  10  signed Q3.6 accumulator output of the PE array.
REQ-010 wr_en  out  1  output feature-map memory write strobe.
REQ-011 wr_addr  out  AW  row-major output pixel address.
REQ-012 wr_data  out  10  Q3.6 pixel value.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse after the last pixel is written.

Function
REQ-015 The FSM states SHALL be IDLE, WAIT, CAPTURE and DONE.
REQ-016 IDLE->WAIT on start=1; the latency counter loads START_LAT-1.
REQ-017 WAIT SHALL decrement on cycles where en=1 and go to CAPTURE when the count reaches 0 with en=1; col=0, row=0.
REQ-018 In CAPTURE, the col counter SHALL advance 0..ROW_PERIOD-1 on each en=1 cycle and then wrap to 0 while row increments.
REQ-019 A sample is valid when col<OUT_W and en=1; only valid samples produce wr_en=1.
REQ-020 Columns OUT_W..ROW_PERIOD-1 are skew/boundary gaps (4 cycles by default); Q SHALL be discarded during them.
REQ-021 Write latency: registered; Q sampled at edge N appears on wr_data/wr_addr with wr_en=1 during cycle N+1.
REQ-022 wr_addr SHALL equal row*OUT_W+col for the written sample, increment only on writes, and never exceed OUT_PIX-1.
REQ-023 After the write for row=OUT_W-1, col=OUT_W-1, the FSM SHALL enter DONE without waiting for trailing gap columns.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 start and done coinciding: start SHALL be ignored; a new frame needs start in IDLE.
REQ-027 en=0 SHALL hold the state, counters and wr_addr; wr_en=0 on the following cycle.
REQ-028 wr_data SHALL pass Q unmodified (no rounding or saturation) unless REQ-033 applies.

Reset
REQ-029 rst=1 SHALL force IDLE, clear all counters, and drive wr_en=0, wr_addr=0, wr_data=0, busy=0 and done=0 on the next edge.
REQ-030 rst SHALL take priority over start and en; rst mid-frame SHALL abort the frame without emitting done.
REQ-031 Memory contents already written are not the block's responsibility after reset.

Configuration
REQ-032 Macro PSUM_RELU_EN selects output activation.
REQ-033 With PSUM_RELU_EN defined, wr_data SHALL be 10'b0 when Q[9]=1, otherwise Q; one extra combinational stage, no added latency.
REQ-034 Without PSUM_RELU_EN, wr_data SHALL be Q unmodified.

Verification
REQ-035 Q=col index (ramp), start, en=1 constantly -> first wr_en 7 cycles after start; writes of addr 0..7 with data 0..7, then 4 idle cycles, repeated for 8 rows; 64 writes in total; done 1 cycle after the addr-63 write.
REQ-036 en low for 3 cycles mid-row 2 at col 5 -> no writes during the stall; addr sequence continuous 21,22,...; done delayed exactly 3 cycles.
REQ-037 rst pulsed at addr 30 -> wr_en=0 and busy=0 next cycle, no done; a following start restarts at addr 0.
REQ-038 Second start pulse during CAPTURE -> ignored; exactly 64 writes and one done.
REQ-039 Q=10'h3C0 (-1.0) constant -> wr_data=10'h000 with PSUM_RELU_EN, 10'h3C0 without.
REQ-040 start in the same cycle as done -> no new frame; busy=0 the following cycle.

Source files
------------

// File: rtl/psum_collector.sv
// psum_collector: collects the PE-array accumulator stream (Q) for one output
// feature map and turns it into row-major memory writes.
//
// Flow: start (in IDLE) arms a latency countdown that covers the PE pipeline.
// Then every en=1 cycle is one column slot. Columns 0..OUT_W-1 are real output
// pixels. Columns OUT_W..ROW_PERIOD-1 are skew gaps and are dropped. After the
// last pixel, done pulses for one cycle.
//
// Ports:
//   sys_clk  in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   frame start pulse, honoured only in IDLE
//   en       in   stream enable; low freezes all state
//   Q        in   signed Q3.6 accumulator sample
//   wr_en    out  output-memory write strobe (registered)
//   wr_addr  out  row-major pixel address of the write
//   wr_data  out  pixel value
//   busy     out  high whenever not IDLE
//   done     out  one-cycle end-of-frame pulse
//
// Build option: define PSUM_RELU_EN to clamp negative samples to zero (ReLU).

module psum_collector #(
    parameter int IMG_WIDTH   = 10,
    parameter int KERNEL_SIZE = 3,
    parameter int START_LAT   = 6,
    localparam int OUT_W      = IMG_WIDTH - KERNEL_SIZE + 1,
    localparam int ROW_PERIOD = IMG_WIDTH + KERNEL_SIZE - 1,
    localparam int OUT_PIX    = OUT_W * OUT_W,
    localparam int AW         = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [9:0]    Q,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [9:0]    wr_data,
    output logic          busy,
    output logic          done
);

    localparam int CW = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;
    localparam int RW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int LW = $clog2(START_LAT) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPTURE, ST_DONE} state_t;

    state_t        r_state, w_state_d;
    logic [LW-1:0] r_lat, w_lat_d;
    logic [CW-1:0] r_col, w_col_d;
    logic [RW-1:0] r_row, w_row_d;
    logic [AW-1:0] r_addr, w_addr_d;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [9:0]    r_wr_data;

    logic          w_sample;
    logic          w_last;
    logic [9:0]    w_act;

`ifdef PSUM_RELU_EN
    assign w_act = Q[9] ? 10'd0 : Q;
`else
    assign w_act = Q;
`endif

    assign w_sample = (r_state == ST_CAPTURE) && en && (r_col < CW'(OUT_W));
    assign w_last   = w_sample && (r_row == RW'(OUT_W - 1)) && (r_col == CW'(OUT_W - 1));

    always_comb begin
        w_state_d = r_state;
        w_lat_d   = r_lat;
        w_col_d   = r_col;
        w_row_d   = r_row;
        w_addr_d  = r_addr;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_lat_d   = LW'(START_LAT - 1);
                    w_col_d   = '0;
                    w_row_d   = '0;
                    w_addr_d  = '0;
                    w_state_d = (START_LAT <= 1) ? ST_CAPTURE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Leave on the en cycle that drains the count, so the first
                // sample is taken START_LAT cycles after start.
                if (en) begin
                    if (r_lat != '0) w_lat_d = r_lat - LW'(1);
                    if (r_lat <= LW'(1)) w_state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (en) begin
                    if (w_last) begin
                        w_state_d = ST_DONE;
                    end else if (r_col == CW'(ROW_PERIOD - 1)) begin
                        w_col_d = '0;
                        w_row_d = r_row + RW'(1);
                    end else begin
                        w_col_d = r_col + CW'(1);
                    end
                    // Keep the address pointer at OUT_PIX-1 after the last write.
                    if (w_sample && !w_last) w_addr_d = r_addr + AW'(1);
                end
            end
            ST_DONE: begin
                // First DONE cycle carries the last write; done follows it.
                if (!r_wr_en) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lat     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_state_d;
            r_lat   <= w_lat_d;
            r_col   <= w_col_d;
            r_row   <= w_row_d;
            r_addr  <= w_addr_d;
            r_wr_en <= w_sample;
            if (w_sample) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_act;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE) && !r_wr_en;

endmodule
